// File: rtl/sokoban_pkg.sv
// Shared encodings for the Sokoban game core: commands, FSM states,
// direction deltas and a constant clog2 helper.
package sokoban_pkg;

   typedef enum logic [2:0] {
      CMD_UP    = 3'd0,
      CMD_DOWN  = 3'd1,
      CMD_LEFT  = 3'd2,
      CMD_RIGHT = 3'd3,
      CMD_UNDO  = 3'd4,
      CMD_RETRY = 3'd5
   } cmd_e;

   typedef enum logic [2:0] {
      ST_EMPTY  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_WON    = 3'd4
   } state_e;

   function automatic int dir_drow(input logic [2:0] c);
      case (c)
         CMD_UP:   return -1;
         CMD_DOWN: return 1;
         default:  return 0;
      endcase
   endfunction

   function automatic int dir_dcol(input logic [2:0] c);
      case (c)
         CMD_LEFT:  return -1;
         CMD_RIGHT: return 1;
         default:   return 0;
      endcase
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/sokoban_undo_ring.sv
// Circular undo history: push writes at the head, pop returns the newest
// entry. When full, a push silently overwrites the oldest entry.
module sokoban_undo_ring
   import sokoban_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int CW    = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [W-1:0]  push_data,
   output logic [W-1:0]  top_data,
   output logic [CW-1:0] count
);
   localparam int PW = clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;

   assign top_data = mem[wr_ptr - PW'(1)];

   // history storage, no reset needed since count gates every read
   always_ff @(posedge clk)
      if (push && !clear) mem[wr_ptr] <= push_data;

   // head pointer and occupancy; count saturates while the pointer keeps wrapping
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PW'(1);
         if (count != CW'(DEPTH)) count <= count + CW'(1);
      end else if (pop && count != '0) begin
         wr_ptr <= wr_ptr - PW'(1);
         count  <= count - CW'(1);
      end

endmodule

// File: rtl/sokoban_core_gen.sv
// Sokoban game core: live board state, command execution and undo history.
// Optional build macro SOKOBAN_STEP_COUNT_EN adds a saturating 'steps' port.
//
//  state     | meaning
//  ----------+------------------------------------------------
//  ST_EMPTY  | no level loaded, commands refused
//  ST_IDLE   | level live, waiting for a command
//  ST_CHECK  | evaluate latched command, apply result
//  ST_COMMIT | re-evaluate win, choose IDLE or WON
//  ST_WON    | level solved, only undo/retry can change state
module sokoban_core_gen
   import sokoban_pkg::*;
#(
   parameter  int COLS  = 8,
   parameter  int ROWS  = 8,
   parameter  int DEPTH = 16,
   localparam int N     = COLS * ROWS,
   localparam int MW    = clog2(N),
   localparam int CW    = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [N-1:0]  init_wall,
   input  logic [N-1:0]  init_box,
   input  logic [N-1:0]  init_dest,
   input  logic [MW-1:0] init_man,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd,
   output logic [N-1:0]  box,
   output logic [MW-1:0] man,
   output logic          win,
   output logic          move_ok,
   output logic          move_err,
`ifdef SOKOBAN_STEP_COUNT_EN
   output logic [15:0]   steps,
`endif
   output logic [CW-1:0] undo_cnt
);
   state_e        state;
   logic [2:0]    cmd_q;
   logic [N-1:0]  wall;
   logic [MW:0]   s1, s2;
   logic [N-1:0]  box_n;
   logic [MW-1:0] man_n;
   logic          dec_ok, dec_err;
   logic          h_push, h_pop, h_clear;
   logic [N+MW-1:0] hist_top;

   // neighbour in direction c; MSB clear when the step leaves the grid
   function automatic logic [MW:0] step(input logic [MW-1:0] idx, input logic [2:0] c);
      int r, col;
      r   = int'(idx) / COLS + dir_drow(c);
      col = int'(idx) % COLS + dir_dcol(c);
      if (r < 0 || r >= ROWS || col < 0 || col >= COLS) return '0;
      return {1'b1, MW'(r * COLS + col)};
   endfunction

   function automatic logic win_of(input logic [N-1:0] b, input logic [N-1:0] d);
      return ((d & ~b) == '0) && (d != '0);
   endfunction

   assign s1 = step(man, cmd_q);
   assign s2 = step(s1[MW-1:0], cmd_q);

   // move / undo / retry evaluation for the latched command
   always_comb begin
      dec_ok  = 1'b0;
      dec_err = 1'b0;
      h_push  = 1'b0;
      h_pop   = 1'b0;
      h_clear = 1'b0;
      box_n   = box;
      man_n   = man;
      if (load) begin
         h_clear = 1'b1;
      end else if (state == ST_CHECK) begin
         case (cmd_q)
            CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT: begin
               if (win || !s1[MW] || wall[s1[MW-1:0]]) begin
                  dec_err = 1'b1;
               end else if (!box[s1[MW-1:0]]) begin
                  dec_ok = 1'b1;
                  h_push = 1'b1;
                  man_n  = s1[MW-1:0];
               end else if (s2[MW] && !wall[s2[MW-1:0]] && !box[s2[MW-1:0]]) begin
                  dec_ok = 1'b1;
                  h_push = 1'b1;
                  box_n[s1[MW-1:0]] = 1'b0;
                  box_n[s2[MW-1:0]] = 1'b1;
                  man_n  = s1[MW-1:0];
               end else begin
                  dec_err = 1'b1;
               end
            end
            CMD_UNDO: begin
               if (undo_cnt != '0) begin
                  dec_ok = 1'b1;
                  h_pop  = 1'b1;
                  {box_n, man_n} = hist_top;
               end else begin
                  dec_err = 1'b1;
               end
            end
            CMD_RETRY: begin
               dec_ok  = 1'b1;
               h_clear = 1'b1;
               box_n   = init_box;
               man_n   = init_man;
            end
            default: dec_err = 1'b1;
         endcase
      end
   end

   sokoban_undo_ring #(.W(N + MW), .DEPTH(DEPTH), .CW(CW)) u_ring (
      .clk       (clk),
      .rst       (rst),
      .push      (h_push),
      .pop       (h_pop),
      .clear     (h_clear),
      .push_data ({box, man}),
      .top_data  (hist_top),
      .count     (undo_cnt)
   );

   // control FSM with registered board state and status outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= ST_EMPTY;
         cmd_q     <= '0;
         wall      <= '0;
         box       <= '0;
         man       <= '0;
         win       <= 1'b0;
         move_ok   <= 1'b0;
         move_err  <= 1'b0;
         cmd_ready <= 1'b0;
      end else if (load) begin
         state     <= ST_IDLE;
         wall      <= init_wall;
         box       <= init_box;
         man       <= init_man;
         win       <= win_of(init_box, init_dest);
         move_ok   <= 1'b0;
         move_err  <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         move_ok  <= 1'b0;
         move_err <= 1'b0;
         case (state)
            ST_EMPTY: ;
            ST_IDLE, ST_WON: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_q     <= cmd;
                  cmd_ready <= 1'b0;
                  state     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               box      <= box_n;
               man      <= man_n;
               win      <= win_of(box_n, init_dest);
               move_ok  <= dec_ok;
               move_err <= dec_err;
               state    <= ST_COMMIT;
            end
            ST_COMMIT: begin
               win       <= win_of(box, init_dest);
               cmd_ready <= 1'b1;
               state     <= win_of(box, init_dest) ? ST_WON : ST_IDLE;
            end
            default: state <= ST_EMPTY;
         endcase
      end

`ifdef SOKOBAN_STEP_COUNT_EN
   // net successful-move counter, saturating at both ends
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         steps <= '0;
      end else if (load) begin
         steps <= '0;
      end else if (state == ST_CHECK && dec_ok) begin
         if (cmd_q == CMD_RETRY) steps <= '0;
         else if (cmd_q == CMD_UNDO) begin
            if (steps != 16'h0000) steps <= steps - 16'd1;
         end else if (steps != 16'hFFFF) steps <= steps + 16'd1;
      end
`endif

endmodule
